// File: rtl/reg_file_sb_if.sv
// reg_file_sb_if: decode/writeback bundle for reg_file_sb; master drives the request side, slave returns read data and busy state
interface reg_file_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              RegWre;
  logic [ADDR_W-1:0] rs;
  logic [ADDR_W-1:0] rt;
  logic [ADDR_W-1:0] WriteReg;
  logic [DATA_W-1:0] WriteData;
  logic              ResvWre;
  logic [ADDR_W-1:0] ResvReg;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;
  logic              Busy1;
  logic              Busy2;
  logic [ADDR_W:0]   BusyCnt;
  modport master (
    output RegWre, rs, rt, WriteReg, WriteData, ResvWre, ResvReg,
    input  ReadData1, ReadData2, Busy1, Busy2, BusyCnt
  );
  modport slave (
    input  RegWre, rs, rt, WriteReg, WriteData, ResvWre, ResvReg,
    output ReadData1, ReadData2, Busy1, Busy2, BusyCnt
  );
endinterface

// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised register file with per-register pending-write busy bits, falling-edge updates
module reg_file_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input logic          CLK,
  input logic          RST_n,
  reg_file_sb_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam bit BP = BYPASS != 0;
  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]  r_busy;
  logic [DEPTH-1:0]  w_busy_nxt;
  logic [ADDR_W:0]   r_cnt;
  logic [ADDR_W:0]   w_cnt_nxt;
  logic              w_we;
  logic              w_rv;
  logic              w_byp1;
  logic              w_byp2;
  assign w_we = bus.RegWre && bus.WriteReg != '0;
  assign w_rv = bus.ResvWre && bus.ResvReg != '0;
  // reserve is applied after the write so it wins on a collision
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_we) w_busy_nxt[bus.WriteReg] = 1'b0;
    if (w_rv) w_busy_nxt[bus.ResvReg] = 1'b1;
    w_cnt_nxt = '0;
    for (int i = 1; i < DEPTH; i++) w_cnt_nxt = w_cnt_nxt + (ADDR_W+1)'(w_busy_nxt[i]);
  end
  always_ff @(negedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_we) r_regs[bus.WriteReg] <= bus.WriteData;
      r_busy <= w_busy_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end
  assign w_byp1 = BP && w_we && bus.WriteReg == bus.rs;
  assign w_byp2 = BP && w_we && bus.WriteReg == bus.rt;
  assign bus.ReadData1 = bus.rs == '0 ? '0 : w_byp1 ? bus.WriteData : r_regs[bus.rs];
  assign bus.ReadData2 = bus.rt == '0 ? '0 : w_byp2 ? bus.WriteData : r_regs[bus.rt];
  assign bus.Busy1     = bus.rs != '0 && !w_byp1 && r_busy[bus.rs];
  assign bus.Busy2     = bus.rt != '0 && !w_byp2 && r_busy[bus.rt];
  assign bus.BusyCnt   = r_cnt;
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: scoreboard bench for reg_file_sb with bypass, no-bypass and narrow 16x8 instances
module tb_reg_file_sb;
  logic CLK = 1'b1;
  logic RST_n = 1'b0;
  reg_file_sb_if #(.DATA_W(32), .ADDR_W(5)) b1 ();
  reg_file_sb_if #(.DATA_W(32), .ADDR_W(5)) b0 ();
  reg_file_sb_if #(.DATA_W(16), .ADDR_W(3)) bs ();
  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut    (.CLK(CLK), .RST_n(RST_n), .bus(b1.slave));
  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dut_nb (.CLK(CLK), .RST_n(RST_n), .bus(b0.slave));
  reg_file_sb #(.DATA_W(16), .ADDR_W(3), .BYPASS(1)) dut_s  (.CLK(CLK), .RST_n(RST_n), .bus(bs.slave));
  always #5 CLK = ~CLK;
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];
  logic [31:0] m_reg [32];
  logic        m_busy [32];
  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask
  task automatic push(string tag, logic [31:0] e);
    tag_q.push_back(tag);
    exp_q.push_back(e);
  endtask
  task automatic pop(logic [31:0] act);
    string t;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_empty: got 0x%0h want none", act);
    end else begin
      t = tag_q.pop_front();
      chk(t, act, exp_q.pop_front());
    end
  endtask
  function automatic logic [31:0] m_rd(logic [4:0] a);
    return a == 0 ? 32'h0 : (b1.RegWre && b1.WriteReg == a) ? b1.WriteData : m_reg[a];
  endfunction
  function automatic logic [31:0] m_bz(logic [4:0] a);
    return a == 0 ? 32'h0 : (b1.RegWre && b1.WriteReg == a) ? 32'h0 : 32'(m_busy[a]);
  endfunction
  function automatic logic [31:0] m_cnt();
    int c = 0;
    for (int i = 1; i < 32; i++) c += int'(m_busy[i]);
    return 32'(c);
  endfunction
  task automatic m_clear();
    for (int i = 0; i < 32; i++) begin
      m_reg[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endtask
  task automatic op(logic we, logic [4:0] wa, logic [31:0] wd, logic rv, logic [4:0] ra);
    b1.RegWre = we; b1.WriteReg = wa; b1.WriteData = wd;
    b1.ResvWre = rv; b1.ResvReg = ra;
    @(negedge CLK);
    if (RST_n) begin
      if (we && wa != 0) begin
        m_reg[wa]  = wd;
        m_busy[wa] = 1'b0;
      end
      if (rv && ra != 0) m_busy[ra] = 1'b1;
    end
    #1 b1.RegWre = 1'b0; b1.ResvWre = 1'b0;
    #1;
  endtask
  task automatic look(string tag, logic [4:0] a1, logic [4:0] a2);
    b1.rs = a1; b1.rt = a2;
    #1;
    push({tag, ".rd1"}, m_rd(a1));
    push({tag, ".rd2"}, m_rd(a2));
    push({tag, ".bz1"}, m_bz(a1));
    push({tag, ".bz2"}, m_bz(a2));
    push({tag, ".cnt"}, m_cnt());
    pop(b1.ReadData1);
    pop(b1.ReadData2);
    pop(32'(b1.Busy1));
    pop(32'(b1.Busy2));
    pop(32'(b1.BusyCnt));
  endtask
  task automatic sop(logic we, logic [2:0] wa, logic [15:0] wd, logic rv, logic [2:0] ra);
    bs.RegWre = we; bs.WriteReg = wa; bs.WriteData = wd;
    bs.ResvWre = rv; bs.ResvReg = ra;
    @(negedge CLK);
    #1 bs.RegWre = 1'b0; bs.ResvWre = 1'b0;
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    m_clear();
    b1.RegWre = 0; b1.rs = 0; b1.rt = 0; b1.WriteReg = 0; b1.WriteData = 0; b1.ResvWre = 0; b1.ResvReg = 0;
    b0.RegWre = 0; b0.rs = 0; b0.rt = 0; b0.WriteReg = 0; b0.WriteData = 0; b0.ResvWre = 0; b0.ResvReg = 0;
    bs.RegWre = 0; bs.rs = 0; bs.rt = 0; bs.WriteReg = 0; bs.WriteData = 0; bs.ResvWre = 0; bs.ResvReg = 0;
    #12 RST_n = 1'b1;
    look("rst", 5, 6);
    op(1, 5, 32'hDEADBEEF, 1, 6);
    look("w5", 5, 6);
    RST_n = 1'b0;
    m_clear();
    look("arst", 5, 6);
    op(1, 8, 32'hCAFEF00D, 1, 8);
    look("inrst", 8, 5);
    RST_n = 1'b1;
    op(1, 3, 32'h12345678, 0, 0);
    look("w3", 0, 3);
    op(1, 0, 32'hFFFFFFFF, 1, 0);
    look("w0", 0, 3);
    op(1, 7, 32'h0BADF00D, 0, 0);
    b1.RegWre = 1; b1.WriteReg = 7; b1.WriteData = 32'hA5A5A5A5;
    look("byp", 7, 3);
    op(1, 7, 32'hA5A5A5A5, 0, 0);
    look("byp_post", 7, 0);
    b0.RegWre = 1; b0.WriteReg = 7; b0.WriteData = 32'h11111111;
    @(negedge CLK);
    #1 b0.rs = 7; b0.WriteData = 32'hA5A5A5A5;
    #1;
    push("nb.old", 32'h11111111);
    pop(b0.ReadData1);
    @(negedge CLK);
    #1 b0.RegWre = 0;
    #1;
    push("nb.new", 32'hA5A5A5A5);
    pop(b0.ReadData1);
    op(0, 0, 0, 1, 4);
    look("resv4", 4, 0);
    op(1, 4, 32'h55, 0, 0);
    look("wr4", 4, 0);
    op(0, 0, 0, 1, 10);
    b1.RegWre = 1; b1.WriteReg = 10; b1.WriteData = 32'h1010;
    look("bzbyp", 10, 4);
    op(1, 10, 32'h1010, 0, 0);
    op(1, 9, 32'h77, 1, 9);
    look("coll", 9, 10);
    op(1, 9, 32'h88, 1, 11);
    look("diff", 9, 11);
    op(0, 0, 0, 1, 11);
    look("renest", 11, 9);
    op(1, 11, 32'h1111, 0, 0);
    look("clr11", 11, 9);
    op(1, 31, 32'hFFFF0001, 1, 30);
    look("top", 31, 30);
    for (int i = 1; i < 8; i++) sop(0, 0, 0, 1, 3'(i));
    push("s.cnt7", 32'd7);
    pop(32'(bs.BusyCnt));
    sop(0, 0, 0, 1, 0);
    push("s.r0", 32'd7);
    pop(32'(bs.BusyCnt));
    bs.rs = 0;
    #1;
    push("s.bz0", 32'd0);
    pop(32'(bs.Busy1));
    for (int i = 1; i < 8; i++) sop(1, 3'(i), 16'(i * 16'h1111), 0, 0);
    push("s.cnt0", 32'd0);
    pop(32'(bs.BusyCnt));
    for (int i = 1; i < 8; i++) begin
      bs.rs = 3'(i); bs.rt = 3'(8 - i);
      #1;
      push("s.rd1", 32'(16'(i * 16'h1111)));
      push("s.rd2", 32'(16'((8 - i) * 16'h1111)));
      pop(32'(bs.ReadData1));
      pop(32'(bs.ReadData2));
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_left: got %0d want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
